// File: rtl/if_stage.sv
// Instruction-fetch stage.
// Takes nextpc from pre-IF and fetches it over the class-SRAM instruction
// port. It holds the returned word and passes {pc, inst, adef} to ID.
// A flush drops any fetch that is still in flight.
module if_stage #(
   parameter int XLEN       = 32,
   parameter bit ADEF_CHECK = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pf_valid,
   input  logic [XLEN-1:0] pf_nextpc,
   output logic            if_allowin,
   input  logic            flush,
   output logic            inst_sram_req,
   output logic [XLEN-1:0] inst_sram_addr,
   input  logic            inst_sram_addr_ok,
   input  logic            inst_sram_data_ok,
   input  logic [XLEN-1:0] inst_sram_rdata,
   input  logic            id_allowin,
   output logic            if_to_id_valid,
   output logic [XLEN-1:0] if_to_id_pc,
   output logic [XLEN-1:0] if_to_id_inst,
   output logic            if_to_id_adef
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t          state_q, state_d;
   logic            discard_q, discard_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic            adef_q, adef_d;

   logic            accept;
   logic            misaligned;

   // A misaligned PC is reported as ADEF and never reaches the SRAM.
   assign misaligned = ADEF_CHECK && (pf_nextpc[1:0] != 2'b00);

   // New PCs are taken when idle, or when the held instruction leaves
   // (consumed by ID or killed by a flush) in the same cycle.
   assign if_allowin = (state_q == IDLE) |
                       ((state_q == HOLD) & (id_allowin | flush));
   assign accept     = pf_valid & if_allowin;

   // Next-state logic: fetch sequencing, flush bookkeeping, PC capture.
   always_comb begin
      state_d   = state_q;
      discard_d = discard_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      adef_d    = adef_q;

      case (state_q)
         REQ: begin
            // The request cannot be withdrawn, so a flush only marks its
            // data for disposal.
            if (flush) discard_d = 1'b1;
            if (inst_sram_addr_ok) state_d = WAIT;
         end
         WAIT: begin
            if (inst_sram_data_ok) begin
               if (discard_q | flush) begin
                  discard_d = 1'b0;
                  state_d   = IDLE;
               end else begin
                  inst_d  = inst_sram_rdata;
                  state_d = HOLD;
               end
            end else if (flush) begin
               discard_d = 1'b1;
            end
         end
         HOLD: begin
            if (id_allowin | flush) state_d = IDLE;
         end
         default: ;
      endcase

      // Accept happens only in IDLE or while leaving HOLD. It overrides
      // the IDLE fallback chosen above.
      if (accept) begin
         pc_d   = pf_nextpc;
         adef_d = misaligned;
         if (misaligned) begin
            inst_d  = '0;
            state_d = HOLD;
         end else begin
            state_d = REQ;
         end
      end
   end

   // State and datapath registers, synchronously reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         discard_q <= 1'b0;
         pc_q      <= '0;
         inst_q    <= '0;
         adef_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         discard_q <= discard_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         adef_q    <= adef_d;
      end
   end

   // Outputs come from registers or state decode only. rdata never reaches
   // the ID side combinationally.
   assign inst_sram_req  = (state_q == REQ);
   assign inst_sram_addr = pc_q;
   assign if_to_id_valid = (state_q == HOLD) & ~flush;
   assign if_to_id_pc    = pc_q;
   assign if_to_id_inst  = inst_q;
   assign if_to_id_adef  = adef_q;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage.
// Directed scenarios are followed by a randomized phase. A transaction-level
// model predicts handshakes and the instruction stream handed to ID.
module tb_if_stage;

   logic        clk;
   logic        reset;
   logic        pf_valid;
   logic [31:0] pf_nextpc;
   logic        if_allowin;
   logic        flush;
   logic        inst_sram_req;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        id_allowin;
   logic        if_to_id_valid;
   logic [31:0] if_to_id_pc;
   logic [31:0] if_to_id_inst;
   logic        if_to_id_adef;

   if_stage #(.XLEN(32), .ADEF_CHECK(1'b1)) dut (
      .clk               (clk),
      .reset             (reset),
      .pf_valid          (pf_valid),
      .pf_nextpc         (pf_nextpc),
      .if_allowin        (if_allowin),
      .flush             (flush),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .id_allowin        (id_allowin),
      .if_to_id_valid    (if_to_id_valid),
      .if_to_id_pc       (if_to_id_pc),
      .if_to_id_inst     (if_to_id_inst),
      .if_to_id_adef     (if_to_id_adef)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Instruction memory contents seen through the SRAM port.
   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h1c000000) return 32'h02800000;
      if (a == 32'h1c000008 || a == 32'h1c000104) return 32'hdeadbeef;
      return {a[15:0], a[31:16]} ^ 32'h5a5ac3c3;
   endfunction

   // ---------------- SRAM responder ----------------
   bit          rnd = 1'b0;
   int          a_delay = 0;
   int          d_delay = 0;

   initial begin
      bit          pend, last_ahs, last_dhs, req_prev, req_now;
      logic [31:0] paddr, last_a;
      int          acnt, dcnt;
      pend = 0; last_ahs = 0; last_dhs = 0; req_prev = 0;
      paddr = '0; last_a = '0; acnt = 0; dcnt = 0;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pend = 0; last_ahs = 0; last_dhs = 0; req_prev = 0; acnt = 0;
            inst_sram_addr_ok = 1'b0;
            inst_sram_data_ok = 1'b0;
            continue;
         end
         if (last_dhs) pend = 0;
         if (last_ahs) begin
            pend  = 1;
            paddr = last_a;
            dcnt  = rnd ? int'($urandom_range(0, 3)) : d_delay;
         end
         req_now = inst_sram_req;
         if (req_now && !req_prev) acnt = rnd ? int'($urandom_range(0, 3)) : a_delay;
         inst_sram_addr_ok = 1'b0;
         if (req_now) begin
            if (acnt == 0) inst_sram_addr_ok = 1'b1;
            else acnt--;
         end
         inst_sram_data_ok = 1'b0;
         inst_sram_rdata   = $urandom;
         if (pend) begin
            if (dcnt == 0) begin
               inst_sram_data_ok = 1'b1;
               inst_sram_rdata   = mem(paddr);
            end else begin
               dcnt--;
            end
         end
         last_ahs = req_now & inst_sram_addr_ok;
         last_a   = inst_sram_addr;
         last_dhs = inst_sram_data_ok;
         req_prev = req_now & ~inst_sram_addr_ok;
      end
   end

   // ---------------- Reference model + scoreboard monitor ----------------
   // A fetch is "busy" from acceptance of an aligned PC until its data
   // returns. Accepted PCs queue up as expected deliveries. A flush erases
   // everything accepted but not yet delivered.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adef;
   } exp_t;

   exp_t        sb[$];
   bit          busy = 0;
   bit          adone = 0;
   logic [31:0] fetch_pc = '0;
   bit          mon_acc = 0;
   bit          mon_fdone = 0;
   int          dead_cnt = 0;

   initial begin
      bit   exp_allow, exp_valid, exp_req, acc;
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (reset) begin
            sb.delete();
            busy = 0; adone = 0; mon_acc = 0; mon_fdone = 0;
            continue;
         end
         exp_allow = !busy && (sb.size() == 0 || id_allowin || flush);
         exp_valid = !busy && sb.size() != 0 && !flush;
         exp_req   = busy && !adone;
         chk("if_allowin", 32'(if_allowin), 32'(exp_allow));
         chk("if_to_id_valid", 32'(if_to_id_valid), 32'(exp_valid));
         chk("inst_sram_req", 32'(inst_sram_req), 32'(exp_req));
         if (exp_req) chk("inst_sram_addr", inst_sram_addr, fetch_pc);

         acc = pf_valid & if_allowin;
         if (if_to_id_valid && id_allowin) begin
            if (if_to_id_inst == 32'hdeadbeef) dead_cnt++;
            if (sb.size() == 0) begin
               chk("delivery_expected", 32'd0, 32'd1);
            end else begin
               e = sb.pop_front();
               chk("id_pc", if_to_id_pc, e.pc);
               chk("id_inst", if_to_id_inst, e.inst);
               chk("id_adef", 32'(if_to_id_adef), 32'(e.adef));
            end
         end
         if (flush) sb.delete();
         if (busy && inst_sram_req && inst_sram_addr_ok) adone = 1;
         if (busy && inst_sram_data_ok) busy = 0;
         if (acc) begin
            if (pf_nextpc[1:0] != 2'b00) begin
               sb.push_back('{pc: pf_nextpc, inst: 32'h0, adef: 1'b1});
            end else begin
               sb.push_back('{pc: pf_nextpc, inst: mem(pf_nextpc), adef: 1'b0});
               busy = 1; adone = 0; fetch_pc = pf_nextpc;
            end
         end
         mon_acc   = acc;
         mon_fdone = flush & if_allowin;
      end
   end

   // ---------------- Stimulus helpers ----------------
   task automatic accept_pc(input logic [31:0] pc);
      bit ok;
      ok = 0;
      pf_valid  = 1'b1;
      pf_nextpc = pc;
      for (int k = 0; k < 50; k++) begin
         #1;
         if (if_allowin) begin ok = 1; break; end
         @(negedge clk);
      end
      chk("accept_in_time", 32'(ok), 32'd1);
      @(negedge clk);
      pf_valid = 1'b0;
   endtask

   task automatic flush_to(input logic [31:0] pc);
      bit ok;
      ok = 0;
      flush     = 1'b1;
      pf_valid  = 1'b1;
      pf_nextpc = pc;
      for (int k = 0; k < 50; k++) begin
         #1;
         if (if_allowin) begin ok = 1; break; end
         @(negedge clk);
      end
      chk("flush_accept_in_time", 32'(ok), 32'd1);
      @(negedge clk);
      flush    = 1'b0;
      pf_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!if_to_id_valid && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("valid_in_time", 32'(if_to_id_valid), 32'd1);
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] p;
      p = 32'h1c000000 | ($urandom_range(0, 4095) << 2);
      if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
      return p;
   endfunction

   // ---------------- Main sequence ----------------
   initial begin
      int          n;
      logic [31:0] npc;
      bit          fl_on;
      reset = 1'b1; pf_valid = 1'b0; pf_nextpc = '0; flush = 1'b0; id_allowin = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_if_allowin", 32'(if_allowin), 32'd1);
      chk("rst_req", 32'(inst_sram_req), 32'd0);
      chk("rst_addr", inst_sram_addr, 32'd0);
      chk("rst_valid", 32'(if_to_id_valid), 32'd0);
      chk("rst_pc", if_to_id_pc, 32'd0);
      chk("rst_inst", if_to_id_inst, 32'd0);
      chk("rst_adef", 32'(if_to_id_adef), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Back-to-back handshakes: three-cycle latency.
      accept_pc(32'h1c000000);
      #1;
      chk("t1_req", 32'(inst_sram_req), 32'd1);
      chk("t1_addr", inst_sram_addr, 32'h1c000000);
      wait_valid(n);
      chk("t1_latency", 32'(n), 32'd2);
      chk("t1_pc", if_to_id_pc, 32'h1c000000);
      chk("t1_inst", if_to_id_inst, 32'h02800000);

      // ID stalls: output held, no new fetch.
      id_allowin = 1'b0;
      repeat (4) begin
         @(negedge clk);
         #1;
         chk("t2_valid_held", 32'(if_to_id_valid), 32'd1);
         chk("t2_pc_held", if_to_id_pc, 32'h1c000000);
         chk("t2_inst_held", if_to_id_inst, 32'h02800000);
         chk("t2_allowin", 32'(if_allowin), 32'd0);
         chk("t2_no_req", 32'(inst_sram_req), 32'd0);
      end
      id_allowin = 1'b1;
      a_delay = 3;
      accept_pc(32'h1c000004);

      // Slow addr_ok: request held steady.
      repeat (3) begin
         #1;
         chk("t3_req_held", 32'(inst_sram_req), 32'd1);
         chk("t3_addr_held", inst_sram_addr, 32'h1c000004);
         chk("t3_allowin", 32'(if_allowin), 32'd0);
         @(negedge clk);
      end
      a_delay = 0;
      wait_valid(n);
      chk("t3_pc", if_to_id_pc, 32'h1c000004);

      // Flush in WAIT: late data dropped, target fetched.
      d_delay = 2;
      accept_pc(32'h1c000008);
      @(negedge clk);
      flush_to(32'h1c000100);
      d_delay = 0;
      wait_valid(n);
      chk("t4_pc", if_to_id_pc, 32'h1c000100);

      // Flush together with data_ok.
      d_delay = 1;
      accept_pc(32'h1c000104);
      @(negedge clk);
      @(negedge clk);
      flush_to(32'h1c000180);
      d_delay = 0;
      id_allowin = 1'b0;
      wait_valid(n);
      chk("t5_pc", if_to_id_pc, 32'h1c000180);
      // Flush in HOLD: the target is accepted in the same cycle.
      flush = 1'b1; pf_valid = 1'b1; pf_nextpc = 32'h1c000200;
      #1;
      chk("t5_valid_killed", 32'(if_to_id_valid), 32'd0);
      chk("t5_allowin", 32'(if_allowin), 32'd1);
      @(negedge clk);
      flush = 1'b0; pf_valid = 1'b0; id_allowin = 1'b1;
      #1;
      chk("t5_req", 32'(inst_sram_req), 32'd1);
      chk("t5_addr", inst_sram_addr, 32'h1c000200);
      wait_valid(n);
      chk("t5_target_pc", if_to_id_pc, 32'h1c000200);

      // Misaligned PC: ADEF without SRAM traffic.
      accept_pc(32'h1c000002);
      #1;
      chk("t6_no_req", 32'(inst_sram_req), 32'd0);
      chk("t6_valid", 32'(if_to_id_valid), 32'd1);
      chk("t6_adef", 32'(if_to_id_adef), 32'd1);
      chk("t6_inst", if_to_id_inst, 32'd0);
      chk("t6_pc", if_to_id_pc, 32'h1c000002);
      @(negedge clk);
      #1;
      chk("t6_still_no_req", 32'(inst_sram_req), 32'd0);
      chk("dropped_data_never_delivered", 32'(dead_cnt), 32'd0);

      // Randomized traffic.
      rnd   = 1'b1;
      npc   = 32'h1c001000;
      fl_on = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (mon_acc) npc = ($urandom_range(0, 7) == 0) ? rand_pc() : npc + 32'd4;
         if (fl_on && mon_fdone) begin
            fl_on = 0;
            flush = 1'b0;
         end
         if (!fl_on && $urandom_range(0, 15) == 0) begin
            fl_on = 1;
            flush = 1'b1;
            npc   = rand_pc();
         end
         pf_valid   = fl_on ? 1'b1 : ($urandom_range(0, 3) != 0);
         pf_nextpc  = npc;
         id_allowin = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      flush = 1'b0; pf_valid = 1'b0; id_allowin = 1'b1;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
